// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed-bus sequencer.
// Turns a decoded processor access into a timed two-phase transaction on the
// RTC address/data bus: an address write (a_d=0), then a data write or read
// (a_d=1). Every bus pin and status output is registered.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for act_rtc with a strobe
// A_SETUP  | address driven, a_d=0, strobes inactive
// A_STROBE | address driven, cs_n/wr_n low
// A_HOLD   | address still driven, strobes released
// GAP      | bus released, a_d=1
// D_SETUP  | data driven on writes, bus released on reads
// D_STROBE | cs_n low with wr_n (write) or rd_n (read) low
// D_HOLD   | strobes released, write data still driven
// DONE     | one-cycle completion, done pulse
module rtc_bus_ctrl #(
  parameter int T_PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act_rtc,
  input  logic [7:0] dir,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] dato_in,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] dato_leido,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CW = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(T_PH - 1);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [7:0]      addr_q, data_q;
  logic            is_wr;
  logic            req, tc;

  logic            cs_d, wr_d, rd_d, a_d_d, oe_d, busy_d, done_d, ovr_d;
  logic [7:0]      out_d;

  assign req = act_rtc & (write_strobe | read_strobe);
  assign tc  = (cnt == CNT_TC);

  // State register and per-phase cycle counter (cleared at each phase change)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE || state == DONE || tc)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  // Next-state: each bus phase lasts T_PH cycles, DONE lasts one
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req) state_nx = A_SETUP;
      A_SETUP:  if (tc)  state_nx = A_STROBE;
      A_STROBE: if (tc)  state_nx = A_HOLD;
      A_HOLD:   if (tc)  state_nx = GAP;
      GAP:      if (tc)  state_nx = D_SETUP;
      D_SETUP:  if (tc)  state_nx = D_STROBE;
      D_STROBE: if (tc)  state_nx = D_HOLD;
      D_HOLD:   if (tc)  state_nx = DONE;
      DONE:              state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  // Capture the request only when accepted; write wins if both strobes are set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= 8'h00;
      data_q <= 8'h00;
      is_wr  <= 1'b0;
    end else if (state == IDLE && req) begin
      addr_q <= dir;
      data_q <= dato_in;
      is_wr  <= write_strobe;
    end
  end

  // Output decode of the current state, fed into the output register below
  always_comb begin
    cs_d   = 1'b1;
    wr_d   = 1'b1;
    rd_d   = 1'b1;
    a_d_d  = 1'b1;
    oe_d   = 1'b0;
    out_d  = 8'h00;
    busy_d = (state != IDLE);
    done_d = 1'b0;
    ovr_d  = req & (state != IDLE);
    case (state)
      A_SETUP, A_HOLD: begin
        a_d_d = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_q;
      end
      A_STROBE: begin
        a_d_d = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_q;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
      end
      D_SETUP, D_HOLD: begin
        oe_d  = is_wr;
        out_d = is_wr ? data_q : 8'h00;
      end
      D_STROBE: begin
        cs_d = 1'b0;
        if (is_wr) begin
          wr_d  = 1'b0;
          oe_d  = 1'b1;
          out_d = data_q;
        end else begin
          rd_d = 1'b0;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Output register: no combinational path from inputs to the bus pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      a_d     <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cs_n    <= cs_d;
      wr_n    <= wr_d;
      rd_n    <= rd_d;
      a_d     <= a_d_d;
      ad_oe   <= oe_d;
      ad_out  <= out_d;
      busy    <= busy_d;
      done    <= done_d;
      overrun <= ovr_d;
    end
  end

  // Read capture. Pins lag the state by one cycle, so the first D_HOLD state
  // cycle is the last cycle rd_n is actually low at the RTC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dato_leido <= 8'h00;
    else if (state == D_HOLD && cnt == '0 && !is_wr)
      dato_leido <= ad_in;
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Testbench for rtc_bus_ctrl: two builds (T_PH=4 and T_PH=1) share the
// processor-side stimulus; a cycle-indexed reference model predicts every pin.
module tb_rtc_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       act_rtc;
  logic [7:0] dir;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] dato_in;

  logic [7:0] ad_in_w  [2];
  logic [7:0] ad_out_w [2];
  logic [7:0] dl_w     [2];
  logic       ad_oe_w  [2];
  logic       a_d_w    [2];
  logic       cs_n_w   [2];
  logic       wr_n_w   [2];
  logic       rd_n_w   [2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic       ovr_w    [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_PH(4)) u0 (
    .clk(clk), .reset(reset), .act_rtc(act_rtc), .dir(dir),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .dato_in(dato_in),
    .ad_in(ad_in_w[0]), .ad_out(ad_out_w[0]), .ad_oe(ad_oe_w[0]), .a_d(a_d_w[0]),
    .cs_n(cs_n_w[0]), .wr_n(wr_n_w[0]), .rd_n(rd_n_w[0]), .dato_leido(dl_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .overrun(ovr_w[0])
  );

  rtc_bus_ctrl #(.T_PH(1)) u1 (
    .clk(clk), .reset(reset), .act_rtc(act_rtc), .dir(dir),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .dato_in(dato_in),
    .ad_in(ad_in_w[1]), .ad_out(ad_out_w[1]), .ad_oe(ad_oe_w[1]), .a_d(a_d_w[1]),
    .cs_n(cs_n_w[1]), .wr_n(wr_n_w[1]), .rd_n(rd_n_w[1]), .dato_leido(dl_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .overrun(ovr_w[1])
  );

  // Reference model state, one slot per build
  int         tp     [2] = '{4, 1};
  bit         act_m  [2];
  int         ts     [2];
  bit         op_wr  [2];
  logic [7:0] addr_m [2];
  logic [7:0] data_m [2];
  logic [7:0] rdv    [2];
  logic [7:0] dl_m   [2];
  bit         ovr_m  [2];
  int         e = 0;
  int         rd_force = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {cs_n, wr_n, rd_n, a_d, ad_oe, busy, done, overrun} for a cycle
  // m cycles after the accept edge. Phase p = (m-1)/T covers T cycles each.
  function automatic logic [7:0] exp_pins(int m, int t, bit w, bit ovr);
    int p;
    logic [6:0] v;
    if (m < 1 || m > 7*t + 1) return {7'b1111000, ovr};
    p = (m - 1) / t;
    case (p)
      0, 2:    v = 7'b1110110;
      1:       v = 7'b0010110;
      3:       v = 7'b1111010;
      4, 6:    v = {4'b1111, w, 2'b10};
      5:       v = w ? 7'b0011110 : 7'b0101010;
      default: v = 7'b1111011;
    endcase
    return {v, ovr};
  endfunction

  task automatic model_step(input int i, input bit req, input bit ws,
                            input logic [7:0] d, input logic [7:0] di);
    bit idle_before;
    idle_before = !act_m[i] || ((e - 1 - ts[i]) >= 7*tp[i] + 1);
    ovr_m[i] = 1'b0;
    if (req) begin
      if (idle_before) begin
        act_m[i]  = 1'b1;
        ts[i]     = e;
        op_wr[i]  = ws;
        addr_m[i] = d;
        data_m[i] = di;
        rdv[i]    = (rd_force >= 0) ? rd_force[7:0] : 8'($urandom);
      end else begin
        ovr_m[i] = 1'b1;
      end
    end
    if (act_m[i] && !op_wr[i] && (e - ts[i]) == 6*tp[i] + 1) dl_m[i] = rdv[i];
  endtask

  task automatic check_outputs(input int i);
    int m;
    logic [7:0] ep, gp;
    m  = act_m[i] ? (e - ts[i]) : -1;
    ep = exp_pins(m, tp[i], op_wr[i], ovr_m[i]);
    gp = {cs_n_w[i], wr_n_w[i], rd_n_w[i], a_d_w[i], ad_oe_w[i], busy_w[i], done_w[i], ovr_w[i]};
    chk($sformatf("u%0d pins m=%0d", i, m), 32'(gp), 32'(ep));
    if (ep[3])
      chk($sformatf("u%0d ad_out m=%0d", i, m), 32'(ad_out_w[i]),
          32'(((m - 1) / tp[i] <= 2) ? addr_m[i] : data_m[i]));
    chk($sformatf("u%0d dato_leido m=%0d", i, m), 32'(dl_w[i]), 32'(dl_m[i]));
    chk($sformatf("u%0d wr_rd_excl", i), 32'(!(wr_n_w[i] == 1'b0 && rd_n_w[i] == 1'b0)), 32'd1);
  endtask

  // Pad read-back carries the RTC value only while rd_n is low; noise otherwise
  task automatic drive_ad_in(input int i);
    int m;
    m = act_m[i] ? (e - ts[i]) : -1;
    if (act_m[i] && !op_wr[i] && m >= 5*tp[i] + 1 && m <= 6*tp[i])
      ad_in_w[i] = rdv[i];
    else
      ad_in_w[i] = 8'($urandom);
  endtask

  task automatic tick(input logic a, input logic [7:0] d, input logic ws,
                      input logic rs, input logic [7:0] di);
    act_rtc = a; dir = d; write_strobe = ws; read_strobe = rs; dato_in = di;
    @(posedge clk);
    e++;
    for (int i = 0; i < 2; i++) model_step(i, a && (ws || rs), ws, d, di);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      drive_ad_in(i);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic reset_mid_cycle();
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset pins", i),
          32'({cs_n_w[i], wr_n_w[i], rd_n_w[i], a_d_w[i], ad_oe_w[i], busy_w[i], done_w[i], ovr_w[i]}),
          32'(8'b11110000));
      chk($sformatf("u%0d reset dato_leido", i), 32'(dl_w[i]), 32'd0);
      act_m[i] = 1'b0;
      dl_m[i]  = 8'h00;
      ovr_m[i] = 1'b0;
    end
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    act_rtc = 1'b0; dir = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0; dato_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      ad_in_w[i] = 8'h00; act_m[i] = 1'b0; ts[i] = 0; op_wr[i] = 1'b0;
      addr_m[i] = 8'h00; data_m[i] = 8'h00; rdv[i] = 8'h00; dl_m[i] = 8'h00; ovr_m[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
    #2 reset = 1'b0;

    // Write 0x59 to register 0x21
    tick(1'b1, 8'h21, 1'b1, 1'b0, 8'h59);
    idle(32);

    // Read register 0x43, RTC returns 0x17
    rd_force = 8'h17;
    tick(1'b1, 8'h43, 1'b0, 1'b1, 8'hAA);
    rd_force = -1;
    idle(32);

    // Second write lands in A_HOLD of the T_PH=4 build -> overrun
    tick(1'b1, 8'h3C, 1'b1, 1'b0, 8'hC3);
    idle(9);
    tick(1'b1, 8'h99, 1'b1, 1'b0, 8'h66);
    idle(32);

    // Both strobes: write wins; strobe without act_rtc: nothing happens
    tick(1'b1, 8'h5A, 1'b1, 1'b1, 8'hA5);
    idle(32);
    tick(1'b0, 8'h12, 1'b1, 1'b0, 8'h34);
    idle(5);

    // Reset in the middle of D_STROBE of a write, then a normal request
    tick(1'b1, 8'h77, 1'b1, 1'b0, 8'h88);
    idle(22);
    reset_mid_cycle();
    tick(1'b1, 8'h0F, 1'b1, 1'b0, 8'hF0);
    idle(32);

    // Back-to-back on the T_PH=1 build: next request in the done cycle
    tick(1'b1, 8'hE1, 1'b1, 1'b0, 8'h1E);
    idle(8);
    tick(1'b1, 8'hE1, 1'b0, 1'b1, 8'h00);
    idle(32);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int s;
      s = $urandom_range(0, 11);
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'(s == 0 || s == 2),
           1'(s == 1 || s == 2), 8'($urandom));
    end
    idle(32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
